// File: rtl/neureka_package.sv
// rtl/neureka_package.sv - shared NEUREKA types and constants for the streamout sequencer
package neureka_package;

    localparam int NEUREKA_NR_PE        = 36;
    localparam int NEUREKA_PE_IDX_W     = $clog2(NEUREKA_NR_PE);
    localparam int NEUREKA_WORDS_PER_PE = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        ARM    = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4
    } streamout_seq_state_t;

    // Serializer/accumulator control bundle, sized for the default engine geometry
    typedef struct packed {
        logic [NEUREKA_NR_PE-1:0]    enable_accumulator;
        logic [NEUREKA_PE_IDX_W-1:0] last_pe;
        logic                        goto_streamout;
        logic                        clear_ser;
        logic [NEUREKA_PE_IDX_W:0]   ser_nb_streams;
        logic [NEUREKA_PE_IDX_W-1:0] ser_first;
    } ctrl_streamout_seq_t;

endpackage

// File: rtl/neureka_mask_scan.sv
// rtl/neureka_mask_scan.sv - popcount, lowest and highest set index of a PE mask
module neureka_mask_scan #(
    parameter int NR_PE    = 36,
    parameter int PE_IDX_W = $clog2(NR_PE)
) (
    input  logic [NR_PE-1:0]    mask,
    output logic [PE_IDX_W:0]   count,
    output logic [PE_IDX_W-1:0] lowest,
    output logic [PE_IDX_W-1:0] highest
);

    localparam logic [PE_IDX_W:0] CNT_ONE = 1;

    // Upward scan leaves the highest index, downward scan leaves the lowest; all zero for an empty mask
    always_comb begin
        count   = '0;
        lowest  = '0;
        highest = '0;
        for (int i = 0; i < NR_PE; i++) begin
            if (mask[i]) begin
                count   = count + CNT_ONE;
                highest = PE_IDX_W'(i);
            end
        end
        for (int j = NR_PE - 1; j >= 0; j--) begin
            if (mask[j]) begin
                lowest = PE_IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/neureka_streamout_sequencer.sv
// rtl/neureka_streamout_sequencer.sv - streamout phase sequencer; optional perf counters under NEUREKA_STREAMOUT_PERF_EN
module neureka_streamout_sequencer
    import neureka_package::*;
#(
    parameter int NR_PE        = NEUREKA_NR_PE,
    parameter int WORDS_PER_PE = NEUREKA_WORDS_PER_PE,
    parameter int PE_IDX_W     = $clog2(NR_PE)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                start_i,
    input  logic [NR_PE-1:0]    pe_mask_i,
    output logic                start_ready_o,
    input  logic                store_valid_i,
    input  logic                store_ready_i,
    output logic [NR_PE-1:0]    enable_accumulator_o,
    output logic [PE_IDX_W-1:0] last_pe_o,
    output logic                goto_streamout_o,
    output logic                clear_ser_o,
    output logic [PE_IDX_W:0]   ser_nb_streams_o,
    output logic [PE_IDX_W-1:0] ser_first_o,
    output logic                busy_o,
    output logic                done_o
`ifdef NEUREKA_STREAMOUT_PERF_EN
    ,
    output logic [31:0]         perf_stall_cycles_o,
    output logic [31:0]         perf_total_cycles_o
`endif
);

    localparam int BEAT_W = (WORDS_PER_PE > 1) ? $clog2(WORDS_PER_PE) : 1;
    localparam logic [BEAT_W-1:0]   BEAT_LAST = BEAT_W'(WORDS_PER_PE - 1);
    localparam logic [BEAT_W-1:0]   BEAT_ONE  = 1;
    localparam logic [PE_IDX_W-1:0] PE_ONE    = 1;
    localparam logic [PE_IDX_W:0]   CNT_ONE   = 1;

    streamout_seq_state_t state;
    logic [BEAT_W-1:0]    beat_cnt;
    logic [PE_IDX_W-1:0]  pe_cnt;

    logic [PE_IDX_W:0]    scan_count;
    logic [PE_IDX_W-1:0]  scan_lowest;
    logic [PE_IDX_W-1:0]  scan_highest;
    logic                 handshake;
    logic                 last_beat;
    logic                 last_stream;

    neureka_mask_scan #(
        .NR_PE    (NR_PE),
        .PE_IDX_W (PE_IDX_W)
    ) i_mask_scan (
        .mask    (pe_mask_i),
        .count   (scan_count),
        .lowest  (scan_lowest),
        .highest (scan_highest)
    );

    assign handshake   = store_valid_i && store_ready_i;
    assign last_beat   = (beat_cnt == BEAT_LAST);
    assign last_stream = (({1'b0, pe_cnt} + CNT_ONE) == ser_nb_streams_o);

    // Sequencer FSM; every output is a register so the datapath sees glitch-free controls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state                <= IDLE;
            beat_cnt             <= '0;
            pe_cnt               <= '0;
            start_ready_o        <= 1'b1;
            enable_accumulator_o <= '0;
            last_pe_o            <= '0;
            goto_streamout_o     <= 1'b0;
            clear_ser_o          <= 1'b0;
            ser_nb_streams_o     <= '0;
            ser_first_o          <= '0;
            busy_o               <= 1'b0;
            done_o               <= 1'b0;
        end else if (clear_i) begin
            state                <= IDLE;
            beat_cnt             <= '0;
            pe_cnt               <= '0;
            start_ready_o        <= 1'b1;
            enable_accumulator_o <= '0;
            last_pe_o            <= '0;
            goto_streamout_o     <= 1'b0;
            clear_ser_o          <= 1'b0;
            ser_nb_streams_o     <= '0;
            ser_first_o          <= '0;
            busy_o               <= 1'b0;
            done_o               <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        if (|pe_mask_i) begin
                            state                <= CLEAR;
                            enable_accumulator_o <= pe_mask_i;
                            last_pe_o            <= scan_highest;
                            ser_nb_streams_o     <= scan_count;
                            ser_first_o          <= scan_lowest;
                            clear_ser_o          <= 1'b1;
                            start_ready_o        <= 1'b0;
                            busy_o               <= 1'b1;
                        end else begin
                            // Nothing to drain: acknowledge immediately without touching the datapath
                            done_o <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    clear_ser_o      <= 1'b0;
                    goto_streamout_o <= 1'b1;
                    state            <= ARM;
                end
                ARM: begin
                    goto_streamout_o <= 1'b0;
                    beat_cnt         <= '0;
                    pe_cnt           <= '0;
                    state            <= STREAM;
                end
                STREAM: begin
                    if (handshake) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            if (last_stream) begin
                                pe_cnt               <= '0;
                                enable_accumulator_o <= '0;
                                done_o               <= 1'b1;
                                state                <= DONE;
                            end else begin
                                pe_cnt <= pe_cnt + PE_ONE;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_ONE;
                        end
                    end
                end
                DONE: begin
                    done_o           <= 1'b0;
                    start_ready_o    <= 1'b1;
                    busy_o           <= 1'b0;
                    last_pe_o        <= '0;
                    ser_nb_streams_o <= '0;
                    ser_first_o      <= '0;
                    state            <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef NEUREKA_STREAMOUT_PERF_EN
    // Saturating stall and occupancy counters, restarted on each accepted start and frozen in IDLE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_stall_cycles_o <= '0;
            perf_total_cycles_o <= '0;
        end else if (clear_i) begin
            perf_stall_cycles_o <= '0;
            perf_total_cycles_o <= '0;
        end else if (state == IDLE) begin
            if (start_i) begin
                perf_stall_cycles_o <= '0;
                perf_total_cycles_o <= '0;
            end
        end else begin
            if (perf_total_cycles_o != '1) begin
                perf_total_cycles_o <= perf_total_cycles_o + 32'd1;
            end
            if ((state == STREAM) && store_valid_i && !store_ready_i &&
                (perf_stall_cycles_o != '1)) begin
                perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
            end
        end
    end
`endif

endmodule
